// File: rtl/drp_regfile.sv
// Parametrised DRP register file: one-at-a-time read/write with fixed response latency.
// Optional DRP_WRITE_MASK_EN: writes only touch bits set in WMASK, other bits keep their value.

module drp_reg_cell #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0,
  parameter logic [DATA_W-1:0] MASK    = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);
  logic [DATA_W-1:0] nextQ;

`ifdef DRP_WRITE_MASK_EN
  assign nextQ = (d & MASK) | (q & ~MASK);
`else
  logic unusedMask;
  assign unusedMask = ^MASK;
  assign nextQ = d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (we) q <= nextQ;
  end
endmodule

module drp_regfile #(
  parameter int                         DATA_W    = 16,
  parameter int                         ADDR_W    = 7,
  parameter int                         NUM_REGS  = 23,
  parameter int unsigned                ADDR_BASE = 7'h06,
  parameter int                         LATENCY   = 2,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS*DATA_W-1:0] WMASK     = '1,
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       DCLK,
  input  logic                       RST,
  input  logic                       PWRDWN,
  input  logic [ADDR_W-1:0]          DADDR,
  input  logic                       DEN,
  input  logic                       DWE,
  input  logic [DATA_W-1:0]          DI,
  output logic [DATA_W-1:0]          DO,
  output logic                       DRDY,
  output logic                       DERR,
  output logic [NUM_REGS*DATA_W-1:0] REGS,
  output logic                       UPD,
  output logic [IDX_W-1:0]           UPD_IDX
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, stateNxt;

  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addrQ, cAddr;
  logic              weQ, cWe;
  logic [DATA_W-1:0] diQ, cDi, rdData;
  logic [ADDR_W:0]   cIdx;
  logic              accept, done, mapped;
  logic [NUM_REGS-1:0]             wrEn;
  logic [NUM_REGS-1:0][DATA_W-1:0] regQ;

  // With LATENCY=1 the request completes on its own sample edge, so the
  // following edge is blocked via DRDY to keep the L+1 transaction period.
  assign accept = (state == IDLE) && DEN && !PWRDWN && !(LATENCY == 1 && DRDY);
  assign done   = (LATENCY == 1) ? accept : ((state == BUSY) && (cnt == 4'd0));

  assign cAddr = (LATENCY == 1) ? DADDR : addrQ;
  assign cWe   = (LATENCY == 1) ? DWE   : weQ;
  assign cDi   = (LATENCY == 1) ? DI    : diQ;

  // Widened by one bit so addresses below the base cannot wrap into the window.
  assign cIdx   = {1'b0, cAddr} - (ADDR_W+1)'(ADDR_BASE);
  assign mapped = ({1'b0, cAddr} >= (ADDR_W+1)'(ADDR_BASE)) &&
                  (cIdx < (ADDR_W+1)'(NUM_REGS));

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (accept && LATENCY != 1) stateNxt = BUSY;
      BUSY:    if (done) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      addrQ <= '0;
      weQ   <= 1'b0;
      diQ   <= '0;
    end else if (accept) begin
      cnt   <= 4'(LATENCY - 1);
      addrQ <= DADDR;
      weQ   <= DWE;
      diQ   <= DI;
    end else if (state == BUSY && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    rdData = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (cIdx == (ADDR_W+1)'(i)) rdData = regQ[i];
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign wrEn[i] = done && cWe && mapped && (cIdx == (ADDR_W+1)'(i));
    drp_reg_cell #(
      .DATA_W (DATA_W),
      .RST_VAL(RESET_VAL[i*DATA_W +: DATA_W]),
      .MASK   (WMASK[i*DATA_W +: DATA_W])
    ) u_reg (
      .clk(DCLK),
      .rst(RST),
      .we (wrEn[i]),
      .d  (cDi),
      .q  (regQ[i])
    );
  end

  assign REGS = regQ;

  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      DO      <= '0;
      DRDY    <= 1'b0;
      DERR    <= 1'b0;
      UPD     <= 1'b0;
      UPD_IDX <= '0;
    end else begin
      DRDY <= done;
      DERR <= done && !mapped;
      UPD  <= done && cWe && mapped;
      if (done && cWe && mapped) UPD_IDX <= cIdx[IDX_W-1:0];
      if (done && !cWe)          DO <= mapped ? rdData : '0;
    end
  end
endmodule

// File: tb/tb_drp_regfile.sv
// Directed bench for drp_regfile: vector table for single transactions plus
// sequences for busy/powerdown/reset corner cases.

module tb_drp_regfile;
  localparam int DW = 16, AW = 7, NR = 23, LAT = 2;
  localparam logic [NR*DW-1:0] RV = {{(NR-3)*DW{1'b0}}, 16'hA500, 32'h0};
  localparam logic [NR*DW-1:0] WM = ~{{(NR-3)*DW{1'b0}}, 16'hFF00, 32'h0};
`ifdef DRP_WRITE_MASK_EN
  localparam bit MASKED = 1'b1;
`else
  localparam bit MASKED = 1'b0;
`endif
  localparam logic [DW-1:0] E2  = MASKED ? 16'hA599 : 16'h9999;
  localparam logic [DW-1:0] EMK = MASKED ? 16'hA5FF : 16'hFFFF;

  logic DCLK, RST, PWRDWN, DEN, DWE, DRDY, DERR, UPD;
  logic [AW-1:0] DADDR;
  logic [DW-1:0] DI, DO;
  logic [NR*DW-1:0] REGS;
  logic [4:0] UPD_IDX;

  drp_regfile #(.RESET_VAL(RV), .WMASK(WM)) dut (
    .DCLK(DCLK), .RST(RST), .PWRDWN(PWRDWN), .DADDR(DADDR), .DEN(DEN), .DWE(DWE),
    .DI(DI), .DO(DO), .DRDY(DRDY), .DERR(DERR), .REGS(REGS), .UPD(UPD), .UPD_IDX(UPD_IDX)
  );

  initial DCLK = 1'b0;
  always #5 DCLK = ~DCLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] di;
    logic [DW-1:0] expDo;
    logic          expErr;
    logic          expUpd;
    logic [4:0]    expIdx;
  } vec_t;

  int total = 0, bad = 0;
  logic [DW-1:0] model [NR];

  task automatic chk(input string nm, input logic [NR*DW-1:0] act, input logic [NR*DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic resetModel();
    logic [NR*DW-1:0] rv;
    rv = RV;
    for (int i = 0; i < NR; i++) model[i] = rv[i*DW +: DW];
  endtask

  task automatic modelWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [NR*DW-1:0] wm;
    logic [DW-1:0] m;
    int i;
    wm = WM;
    if (a >= 7'h06 && (int'(a) - 6) < NR) begin
      i = int'(a) - 6;
      m = MASKED ? wm[i*DW +: DW] : '1;
      model[i] = (d & m) | (model[i] & ~m);
    end
  endtask

  task automatic xact(input vec_t v, input string tag);
    int lat;
    @(negedge DCLK);
    DADDR = v.addr; DWE = v.we; DI = v.di; DEN = 1'b1;
    @(negedge DCLK);
    DEN = 1'b0;
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) @(negedge DCLK);
      @(posedge DCLK); #1;
      if (DRDY) begin lat = n; break; end
    end
    chk({tag, " latency"}, lat, LAT);
    chk({tag, " DO"}, DO, v.expDo);
    chk({tag, " DERR"}, DERR, v.expErr);
    chk({tag, " UPD"}, UPD, v.expUpd);
    if (v.expUpd) chk({tag, " UPD_IDX"}, UPD_IDX, v.expIdx);
    if (v.we) modelWrite(v.addr, v.di);
    chk({tag, " REGS"}, REGS, flat());
    @(posedge DCLK); #1;
    chk({tag, " DRDY drop"}, {DRDY, UPD, DERR}, 3'b000);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [11];
    logic [7:0] pat;
    int cnt;
    vec_t v;

    // addr, we, di, expDo, expErr, expUpd, expIdx
    vecs[0]  = '{7'h08, 1'b1, 16'h9999, 16'h0000, 1'b0, 1'b1, 5'd2};
    vecs[1]  = '{7'h08, 1'b0, 16'h0000, E2,       1'b0, 1'b0, 5'd0};
    vecs[2]  = '{7'h06, 1'b1, 16'h1234, E2,       1'b0, 1'b1, 5'd0};
    vecs[3]  = '{7'h1C, 1'b1, 16'hBEEF, E2,       1'b0, 1'b1, 5'd22};
    vecs[4]  = '{7'h1C, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 5'd0};
    vecs[5]  = '{7'h1D, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'd0};
    vecs[6]  = '{7'h05, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'd0};
    vecs[7]  = '{7'h7F, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 5'd0};
    vecs[8]  = '{7'h00, 1'b1, 16'h5555, 16'h0000, 1'b1, 1'b0, 5'd0};
    vecs[9]  = '{7'h06, 1'b0, 16'h0000, 16'h1234, 1'b0, 1'b0, 5'd0};
    vecs[10] = '{7'h07, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 5'd0};

    RST = 1'b1; PWRDWN = 1'b0; DEN = 1'b0; DWE = 1'b0; DADDR = '0; DI = '0;
    resetModel();
    repeat (2) @(posedge DCLK);
    #1;
    chk("reset DO", DO, 16'h0);
    chk("reset flags", {DRDY, DERR, UPD}, 3'b000);
    chk("reset UPD_IDX", UPD_IDX, 5'd0);
    chk("reset REGS", REGS, RV);
    @(negedge DCLK) RST = 1'b0;
    cnt = 0;
    repeat (5) begin @(posedge DCLK); #1; cnt += int'(DRDY); end
    chk("post-reset DRDY", cnt, 0);

    for (int i = 0; i < 11; i++) xact(vecs[i], $sformatf("vec%0d", i));

    // DEN held for 6 edges: accept e0, done e2, accept e3, done e5
    @(negedge DCLK);
    DADDR = 7'h06; DWE = 1'b0; DEN = 1'b1;
    pat = '0;
    for (int e = 0; e < 8; e++) begin
      @(posedge DCLK); #1;
      pat[e] = DRDY;
      if (e == 5) DEN = 1'b0;
    end
    chk("busy DRDY pattern", pat, 8'b0010_0100);
    chk("busy DO", DO, 16'h1234);

    @(negedge DCLK);
    PWRDWN = 1'b1; DEN = 1'b1;
    cnt = 0;
    repeat (10) begin @(posedge DCLK); #1; cnt += int'(DRDY); end
    DEN = 1'b0;
    chk("pwrdwn DRDY count", cnt, 0);
    @(negedge DCLK) PWRDWN = 1'b0;

    // PWRDWN rising while busy must not abort the write
    @(negedge DCLK);
    DADDR = 7'h07; DWE = 1'b1; DI = 16'h0042; DEN = 1'b1;
    @(posedge DCLK); #1;
    DEN = 1'b0; PWRDWN = 1'b1;
    @(posedge DCLK); #1;
    chk("pwrdwn mid k+1 DRDY", DRDY, 1'b0);
    @(posedge DCLK); #1;
    chk("pwrdwn mid DRDY/UPD", {DRDY, UPD, DERR}, 3'b110);
    chk("pwrdwn mid UPD_IDX", UPD_IDX, 5'd1);
    modelWrite(7'h07, 16'h0042);
    chk("pwrdwn mid REGS", REGS, flat());
    @(negedge DCLK) PWRDWN = 1'b0;

    // reset one edge into a write aborts it
    @(negedge DCLK);
    DADDR = 7'h08; DWE = 1'b1; DI = 16'h0F0F; DEN = 1'b1;
    @(posedge DCLK); #1;
    DEN = 1'b0;
    @(posedge DCLK); #1;
    RST = 1'b1;
    #2;
    chk("rst-mid reg2", REGS[47:32], 16'hA500);
    chk("rst-mid REGS", REGS, RV);
    @(negedge DCLK) RST = 1'b0;
    resetModel();
    cnt = 0;
    repeat (5) begin @(posedge DCLK); #1; cnt += int'(DRDY); end
    chk("rst-mid DRDY count", cnt, 0);
    chk("rst-mid DO", DO, 16'h0);

    v = '{7'h08, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 5'd2};
    xact(v, "mask write");
    v = '{7'h08, 1'b0, 16'h0000, EMK, 1'b0, 1'b0, 5'd0};
    xact(v, "mask read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
